// File: rtl/scu_pkg.sv
// Shared definitions for the SCU pipeline: default widths, ALU opcodes and
// the predicate that tells which opcodes update the condition flags.
package scu_pkg;
    localparam int DW_DEF = 32;
    localparam int RW_DEF = 6;

    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_NEG  = 4'b0011;
    localparam logic [3:0] OP_INC  = 4'b0100;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    function automatic logic sets_flags(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NEG) || (op == OP_INC);
    endfunction
endpackage

// File: rtl/scu_alu.sv
// Combinational SCU ALU: result plus the zero/negative indications for it.
module scu_alu
    import scu_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          zero,
    output logic          neg
);
    always_comb begin
        result = '0;
        case (op)
            OP_PASS: result = b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_NEG:  result = '0 - a;
            OP_INC:  result = a + {{(DW-1){1'b0}}, 1'b1};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
    assign neg  = result[DW-1];
endmodule

// File: rtl/ex_stage.sv
// SCU execute stage: ALU, Z/N flags, branch resolution with wrong-path
// squashing, and the EX/MEM pipeline register.
module ex_stage
    import scu_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int RW     = RW_DEF,
    parameter int SQUASH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          MemWrite,
    input  logic          MemRead,
    input  logic          JumpMem,
    input  logic          Jump,
    input  logic          BranchZero,
    input  logic          BranchNeg,
    input  logic          PCtoReg,
    input  logic          MemToReg,
    input  logic          RegWrite,
    input  logic          ALUMux,
    input  logic [3:0]    ALUOP,
    input  logic [DW-1:0] rs,
    input  logic [DW-1:0] rt,
    input  logic [RW-1:0] rd,
    input  logic [DW-1:0] adder,
    input  logic [DW-1:0] signExtend,
    output logic          mem_valid,
    output logic          MemWrite_m,
    output logic          MemRead_m,
    output logic          JumpMem_m,
    output logic          PCtoReg_m,
    output logic          MemToReg_m,
    output logic          RegWrite_m,
    output logic [DW-1:0] alu_result,
    output logic [DW-1:0] store_data,
    output logic [RW-1:0] rd_m,
    output logic [DW-1:0] pc_plus_m,
    output logic          redirect,
    output logic [DW-1:0] redirect_target,
    output logic          flag_z,
    output logic          flag_n
);
    localparam int CW = $clog2(SQUASH + 1);

    logic [DW-1:0] op_b, alu_res;
    logic          alu_zero, alu_neg, live, taken;

    logic          valid_q, valid_d;
    logic [5:0]    ctrl_q, ctrl_d;
    logic [DW-1:0] alu_q, alu_d, sdata_q, sdata_d, pc_q, pc_d, tgt_q, tgt_d;
    logic [RW-1:0] rd_q, rd_d;
    logic          redir_q, redir_d, z_q, z_d, n_q, n_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign op_b = ALUMux ? signExtend : rt;

    scu_alu #(.DW(DW)) u_alu (
        .op     (ALUOP),
        .a      (rs),
        .b      (op_b),
        .result (alu_res),
        .zero   (alu_zero),
        .neg    (alu_neg)
    );

    assign live  = (cnt_q == '0);
    // Branches test the flags left by the previous flag-setting instruction.
    assign taken = Jump | (BranchZero & z_q) | (BranchNeg & n_q);

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        alu_d   = alu_q;
        sdata_d = sdata_q;
        rd_d    = rd_q;
        pc_d    = pc_q;
        redir_d = redir_q;
        tgt_d   = tgt_q;
        z_d     = z_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            valid_d = live;
            ctrl_d  = {MemWrite, MemRead, JumpMem, PCtoReg, MemToReg, RegWrite} & {6{live}};
            alu_d   = alu_res;
            sdata_d = rt;
            rd_d    = rd;
            pc_d    = adder;
            redir_d = 1'b0;
            if (live) begin
                if (sets_flags(ALUOP)) begin
                    z_d = alu_zero;
                    n_d = alu_neg;
                end
                if (taken) begin
                    redir_d = 1'b1;
                    tgt_d   = rs;
                    cnt_d   = CW'(SQUASH);
                end
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            alu_q   <= '0;
            sdata_q <= '0;
            rd_q    <= '0;
            pc_q    <= '0;
            redir_q <= 1'b0;
            tgt_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            alu_q   <= alu_d;
            sdata_q <= sdata_d;
            rd_q    <= rd_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            tgt_q   <= tgt_d;
            z_q     <= z_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_valid = valid_q;
    assign {MemWrite_m, MemRead_m, JumpMem_m, PCtoReg_m, MemToReg_m, RegWrite_m} = ctrl_q;
    assign alu_result      = alu_q;
    assign store_data      = sdata_q;
    assign rd_m            = rd_q;
    assign pc_plus_m       = pc_q;
    assign redirect        = redir_q;
    assign redirect_target = tgt_q;
    assign flag_z          = z_q;
    assign flag_n          = n_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: a reference model pushes expected EX/MEM state
// into a scoreboard queue per step; it is popped and compared after the edge.
module tb_ex_stage;
    logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0;
    logic        MemWrite = 0, MemRead = 0, JumpMem = 0, Jump = 0, BranchZero = 0, BranchNeg = 0;
    logic        PCtoReg = 0, MemToReg = 0, RegWrite = 0, ALUMux = 0;
    logic [3:0]  ALUOP = 4'hF;
    logic [31:0] rs = 0, rt = 0, adder = 0, signExtend = 0;
    logic [5:0]  rd = 0;
    logic        mem_valid, MemWrite_m, MemRead_m, JumpMem_m, PCtoReg_m, MemToReg_m, RegWrite_m;
    logic [31:0] alu_result, store_data, pc_plus_m, redirect_target;
    logic [5:0]  rd_m;
    logic        redirect, flag_z, flag_n;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .MemWrite(MemWrite), .MemRead(MemRead), .JumpMem(JumpMem), .Jump(Jump),
        .BranchZero(BranchZero), .BranchNeg(BranchNeg), .PCtoReg(PCtoReg),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUMux(ALUMux), .ALUOP(ALUOP),
        .rs(rs), .rt(rt), .rd(rd), .adder(adder), .signExtend(signExtend),
        .mem_valid(mem_valid), .MemWrite_m(MemWrite_m), .MemRead_m(MemRead_m),
        .JumpMem_m(JumpMem_m), .PCtoReg_m(PCtoReg_m), .MemToReg_m(MemToReg_m),
        .RegWrite_m(RegWrite_m), .alu_result(alu_result), .store_data(store_data),
        .rd_m(rd_m), .pc_plus_m(pc_plus_m), .redirect(redirect),
        .redirect_target(redirect_target), .flag_z(flag_z), .flag_n(flag_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        mw, mr, jm, j, bz, bn, p2r, m2r, rw, amux, stl;
        logic [3:0]  op;
        logic [31:0] a, b, imm, pc;
        logic [5:0]  d;
    } stim_t;

    typedef struct packed {
        logic        vld;
        logic [5:0]  ctrl;
        logic [31:0] alu, sd, pc, tgt;
        logic [5:0]  d;
        logic        redir, z, n;
    } exp_t;

    exp_t     sb[$];
    exp_t     m;
    int       m_cnt;
    int       n_vec = 0, n_bad = 0;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'h0: return b;
            4'h1: return a + b;
            4'h2: return a - b;
            4'h3: return 32'd0 - a;
            4'h4: return a + 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    function automatic stim_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic rw, input logic [5:0] d);
        stim_t s;
        s = '0;
        s.op = op; s.a = a; s.b = b; s.rw = rw; s.d = d; s.pc = a + 32'h1000;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".valid"}, 32'(mem_valid), 32'(e.vld));
        chk({tag, ".ctrl"},  32'({MemWrite_m, MemRead_m, JumpMem_m, PCtoReg_m, MemToReg_m, RegWrite_m}), 32'(e.ctrl));
        chk({tag, ".alu"},   alu_result, e.alu);
        chk({tag, ".sd"},    store_data, e.sd);
        chk({tag, ".rd"},    32'(rd_m), 32'(e.d));
        chk({tag, ".pc"},    pc_plus_m, e.pc);
        chk({tag, ".redir"}, 32'(redirect), 32'(e.redir));
        chk({tag, ".tgt"},   redirect_target, e.tgt);
        chk({tag, ".z"},     32'(flag_z), 32'(e.z));
        chk({tag, ".n"},     32'(flag_n), 32'(e.n));
    endtask

    task automatic apply(input string tag, input stim_t s);
        logic [31:0] r;
        logic        live, taken;
        stall = s.stl; MemWrite = s.mw; MemRead = s.mr; JumpMem = s.jm; Jump = s.j;
        BranchZero = s.bz; BranchNeg = s.bn; PCtoReg = s.p2r; MemToReg = s.m2r;
        RegWrite = s.rw; ALUMux = s.amux; ALUOP = s.op; rs = s.a; rt = s.b;
        signExtend = s.imm; adder = s.pc; rd = s.d;
        if (!s.stl) begin
            r     = alu_ref(s.op, s.a, s.amux ? s.imm : s.b);
            live  = (m_cnt == 0);
            taken = live && (s.j || (s.bz && m.z) || (s.bn && m.n));
            m.vld  = live;
            m.ctrl = live ? {s.mw, s.mr, s.jm, s.p2r, s.m2r, s.rw} : 6'b0;
            m.alu = r; m.sd = s.b; m.d = s.d; m.pc = s.pc;
            if (live && s.op inside {4'h1, 4'h2, 4'h3, 4'h4}) begin
                m.z = (r == 32'd0);
                m.n = r[31];
            end
            m.redir = taken;
            if (taken) begin
                m.tgt = s.a;
                m_cnt = 2;
            end else if (!live) begin
                m_cnt--;
            end
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
        check_all(tag, sb.pop_front());
    endtask

    stim_t s;

    initial begin
        m = '0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", '0);
        rst_n = 1'b1;

        apply("add", mk(4'h1, 32'd5, 32'd7, 1'b1, 6'd3));
        chk("add.result12", alu_result, 32'd12);
        chk("add.rwm", 32'(RegWrite_m), 32'd1);

        apply("sub", mk(4'h2, 32'd3, 32'd5, 1'b1, 6'd4));
        chk("sub.n", 32'(flag_n), 32'd1);
        s = mk(4'hF, 32'h40, 32'd0, 1'b0, 6'd0); s.bn = 1'b1;
        apply("bneg", s);
        chk("bneg.redir", 32'(redirect), 32'd1);
        chk("bneg.tgt", redirect_target, 32'h40);
        apply("kill1", mk(4'h1, 32'd1, 32'd1, 1'b1, 6'd5));
        chk("kill1.valid", 32'(mem_valid), 32'd0);
        chk("kill1.redir", 32'(redirect), 32'd0);
        apply("kill2", mk(4'h1, 32'd1, 32'd1, 1'b1, 6'd5));
        apply("live3", mk(4'h1, 32'd2, 32'd2, 1'b1, 6'd6));
        chk("live3.valid", 32'(mem_valid), 32'd1);

        apply("zero", mk(4'h1, 32'd0, 32'd0, 1'b1, 6'd7));
        apply("pass", mk(4'h0, 32'd1, 32'd9, 1'b1, 6'd8));
        chk("pass.zkept", 32'(flag_z), 32'd1);
        s = mk(4'hF, 32'h10, 32'd0, 1'b0, 6'd0); s.bz = 1'b1;
        apply("bz_taken", s);
        chk("bz_taken.redir", 32'(redirect), 32'd1);
        apply("nop_k1", mk(4'hF, 32'd0, 32'd0, 1'b0, 6'd0));
        apply("nop_k2", mk(4'hF, 32'd0, 32'd0, 1'b0, 6'd0));
        apply("zero2", mk(4'h1, 32'd0, 32'd0, 1'b1, 6'd7));
        apply("inc", mk(4'h4, 32'd0, 32'd0, 1'b1, 6'd9));
        apply("bz_nt", s);
        chk("bz_nt.redir", 32'(redirect), 32'd0);

        s = mk(4'hF, 32'h20, 32'd0, 1'b0, 6'd0); s.j = 1'b1;
        apply("jump", s);
        s = mk(4'hF, 32'h99, 32'd0, 1'b0, 6'd0); s.j = 1'b1; s.stl = 1'b1;
        apply("stall", s);
        chk("stall.redir", 32'(redirect), 32'd1);
        chk("stall.tgt", redirect_target, 32'h20);
        apply("jk1", mk(4'h1, 32'd3, 32'd3, 1'b1, 6'd1));
        chk("jk1.valid", 32'(mem_valid), 32'd0);
        apply("jk2", mk(4'h1, 32'd3, 32'd3, 1'b1, 6'd1));
        chk("jk2.valid", 32'(mem_valid), 32'd0);
        apply("jlive", mk(4'h1, 32'hFFFF_FFFF, 32'd0, 1'b1, 6'd2));
        chk("jlive.valid", 32'(mem_valid), 32'd1);

        s = mk(4'hF, 32'h30, 32'd0, 1'b0, 6'd0); s.j = 1'b1;
        apply("j2", s);
        s = mk(4'hF, 32'h50, 32'd0, 1'b0, 6'd0); s.j = 1'b1;
        apply("j_in_sq", s);
        chk("j_in_sq.redir", 32'(redirect), 32'd0);
        chk("j_in_sq.tgt", redirect_target, 32'h30);

        // Asynchronous reset in the middle of the squash window.
        #2 rst_n = 1'b0;
        #1;
        m = '0; m_cnt = 0;
        check_all("midrst", '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        apply("after_rst", mk(4'h1, 32'd1, 32'd2, 1'b1, 6'd11));
        chk("after_rst.valid", 32'(mem_valid), 32'd1);

        s = mk(4'h1, 32'h100, 32'hAB, 1'b0, 6'd0); s.amux = 1'b1; s.imm = 32'd4; s.mw = 1'b1;
        apply("store", s);
        chk("store.addr", alu_result, 32'h104);
        chk("store.data", store_data, 32'hAB);
        chk("store.mw", 32'(MemWrite_m), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
